// File: rtl/pkt_meta_pkg.sv
// Shared packet-metadata definitions: EtherType field location, classification codes and
// the steering state encoding used by the ingress stage and its downstream consumers.
package pkt_meta_pkg;

  localparam int ETYPE_LSB = 96;
  localparam int ETYPE_W   = 16;
  localparam logic [ETYPE_W-1:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [ETYPE_W-1:0] ETYPE_IPV6 = 16'h86DD;

  typedef enum logic [1:0] {
    META = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DST_P0   = 2'd0,
    DST_P1   = 2'd1,
    DST_DROP = 2'd2
  } dst_t;

  function automatic dst_t classify(input logic [ETYPE_W-1:0] etype);
    dst_t dst;
    case (etype)
      ETYPE_IPV4: dst = DST_P0;
      ETYPE_IPV6: dst = DST_P1;
      default:    dst = DST_DROP;
    endcase
    return dst;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry valid/ready output register: one cycle of latency, full throughput when the
// consumer drains and a new beat loads in the same cycle.
module axis_out_reg #(
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              ld_err,
  output logic              ld_ready,
  input  logic              m_tready,
  output logic              m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              m_terr
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  // Next-state: a load always wins over a drain so back-to-back beats keep tvalid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = err_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = ld_data;
      last_d  = ld_last;
      err_d   = ld_err;
    end else if (m_tready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Register stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign ld_ready = !valid_q || m_tready;
  assign m_tvalid = valid_q;
  assign m_tdata  = data_q;
  assign m_tlast  = last_q;
  assign m_terr   = err_q;

endmodule

// File: rtl/meta_steer.sv
// Strips the metadata beat of each packet, classifies it by EtherType and steers the
// payload beats to the IPv4 port, the IPv6 port, or discards them, keeping statistics.
module meta_steer
  import pkt_meta_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int META_W = 356,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  input  logic              s_tuser,
  output logic              m0_tvalid,
  input  logic              m0_tready,
  output logic [DATA_W-1:0] m0_tdata,
  output logic              m0_tlast,
  output logic              m0_terr,
  output logic              m1_tvalid,
  input  logic              m1_tready,
  output logic [DATA_W-1:0] m1_tdata,
  output logic              m1_tlast,
  output logic              m1_terr,
  output logic [CNT_W-1:0]  fwd0_cnt,
  output logic [CNT_W-1:0]  fwd1_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  // EtherType must sit inside the metadata field; a too-narrow META_W falls back to bit 0.
  localparam int ETYPE_POS = (ETYPE_LSB + ETYPE_W <= META_W) ? ETYPE_LSB : 0;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] fwd0_q, fwd0_d;
  logic [CNT_W-1:0] fwd1_q, fwd1_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic             ld0_s, ld1_s;
  logic             ld_last_s, ld_err_s;
  logic             rdy0_s, rdy1_s;
  logic             s_tready_s;
  logic             acc_s;
  logic [ETYPE_W-1:0] etype_s;

  assign etype_s = s_tdata[ETYPE_POS +: ETYPE_W];
  assign acc_s   = s_tvalid && s_tready_s;

  // Next-state, handshake and statistics; at most one counter moves per accepted beat.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    fwd0_d     = fwd0_q;
    fwd1_d     = fwd1_q;
    drop_d     = drop_q;
    err_d      = err_q;
    ld0_s      = 1'b0;
    ld1_s      = 1'b0;
    ld_last_s  = s_tlast;
    ld_err_s   = 1'b0;
    s_tready_s = 1'b1;
    case (state_q)
      META: begin
        s_tready_s = 1'b1;
        if (acc_s && s_tuser && !s_tlast) begin
          case (classify(etype_s))
            DST_P0: begin
              sel_d   = 1'b0;
              state_d = FWD;
              fwd0_d  = fwd0_q + CNT_W'(1);
            end
            DST_P1: begin
              sel_d   = 1'b1;
              state_d = FWD;
              fwd1_d  = fwd1_q + CNT_W'(1);
            end
            default: begin
              state_d = DROP;
              drop_d  = drop_q + CNT_W'(1);
            end
          endcase
        end else if (acc_s) begin
          // Empty metadata packet, or payload without metadata.
          err_d   = err_q + CNT_W'(1);
          state_d = (s_tuser || s_tlast) ? META : DROP;
        end else begin
          state_d = META;
        end
      end
      FWD: begin
        s_tready_s = sel_q ? rdy1_s : rdy0_s;
        if (acc_s) begin
          ld0_s = !sel_q;
          ld1_s = sel_q;
          if (s_tuser) begin
            // Premature metadata closes the current packet as truncated.
            ld_last_s = 1'b1;
            ld_err_s  = 1'b1;
            err_d     = err_q + CNT_W'(1);
            state_d   = s_tlast ? META : DROP;
          end else begin
            state_d = s_tlast ? META : FWD;
          end
        end else begin
          state_d = FWD;
        end
      end
      DROP: begin
        s_tready_s = 1'b1;
        if (acc_s && s_tlast) begin
          state_d = META;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = META;
      end
    endcase
  end

  // State, selection and statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= META;
      sel_q   <= 1'b0;
      fwd0_q  <= '0;
      fwd1_q  <= '0;
      drop_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      fwd0_q  <= fwd0_d;
      fwd1_q  <= fwd1_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  axis_out_reg #(.DATA_W(DATA_W)) u_out0 (
    .clk      (clk),
    .rst      (rst),
    .load     (ld0_s),
    .ld_data  (s_tdata),
    .ld_last  (ld_last_s),
    .ld_err   (ld_err_s),
    .ld_ready (rdy0_s),
    .m_tready (m0_tready),
    .m_tvalid (m0_tvalid),
    .m_tdata  (m0_tdata),
    .m_tlast  (m0_tlast),
    .m_terr   (m0_terr)
  );

  axis_out_reg #(.DATA_W(DATA_W)) u_out1 (
    .clk      (clk),
    .rst      (rst),
    .load     (ld1_s),
    .ld_data  (s_tdata),
    .ld_last  (ld_last_s),
    .ld_err   (ld_err_s),
    .ld_ready (rdy1_s),
    .m_tready (m1_tready),
    .m_tvalid (m1_tvalid),
    .m_tdata  (m1_tdata),
    .m_tlast  (m1_tlast),
    .m_terr   (m1_terr)
  );

  assign s_tready = s_tready_s;
  assign fwd0_cnt = fwd0_q;
  assign fwd1_cnt = fwd1_q;
  assign drop_cnt = drop_q;
  assign err_cnt  = err_q;

endmodule

// File: doc/meta_steer.md
Name: meta_steer

Overview:
- Sits directly downstream of the AXI ingress stage (payload/metadata FIFO plus packet emitter).
- Consumes its 512-bit stream, in which every packet is one metadata beat (TUSER=1, metadata in TDATA[355:0]) followed by one or more payload beats (TUSER=0, TLAST on the final beat).
- Strips the metadata beat, classifies the packet by EtherType, and steers the payload to one of two output streams or drops it.
- Maintains forward, drop and protocol-error statistics.

Parameters:
- DATA_W, 512, stream data width.
- META_W, 356, metadata width carried in the low bits of the metadata beat.
- CNT_W, 32, statistics counter width; counters wrap modulo 2^CNT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock domain, asynchronous, active-low.
- s_tvalid  in  1  upstream valid.
- s_tready  out  1  upstream ready.
- s_tdata  in  DATA_W  upstream data.
- s_tlast  in  1  upstream last beat of packet.
- s_tuser  in  1  1 = metadata beat.
- m0_tvalid/m1_tvalid  out  1  port 0 (IPv4) and port 1 (IPv6) valid.
- m0_tready/m1_tready  in  1  per-port ready.
- m0_tdata/m1_tdata  out  DATA_W  per-port payload.
- m0_tlast/m1_tlast  out  1  per-port last beat.
- m0_terr/m1_terr  out  1  marks a truncated packet (valid only with tlast).
- fwd0_cnt/fwd1_cnt  out  CNT_W  packets steered to each port.
- drop_cnt  out  CNT_W  packets dropped by classification.
- err_cnt  out  CNT_W  protocol errors.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=META; all m*_tvalid/tlast/terr=0; m*_tdata=0; all counters=0; sel=0.
  - Asserting reset mid-packet discards everything in flight. The first beat after release must be a metadata beat.
- Classification:
  - etype = s_tdata[111:96] of the metadata beat.
  - 0x0800 → port 0; 0x86DD → port 1; any other value → drop.
- States:
  - META: s_tready=1.
    - Accepted TUSER=1 and TLAST=0: register sel, go to FWD (or DROP); increment the matching fwd/drop counter in the same cycle.
    - TUSER=1 and TLAST=1 (metadata with no payload): err_cnt+1, stay in META.
    - TUSER=0 (orphan payload): err_cnt+1, go to DROP; if TLAST=1 on that beat, stay in META.
  - FWD: s_tready = !mX_tvalid || mX_tready, where X=sel; the other port is never loaded.
    - Accepted TUSER=0: load output register X with tdata/tlast, terr=0. Go to META on TLAST.
    - Accepted TUSER=1 (premature metadata): load X with that beat's data, tlast=1, terr=1; err_cnt+1; go to DROP unless TLAST=1, in which case go to META. The beat is not reinterpreted as metadata.
  - DROP: s_tready=1; beats are discarded; go to META on an accepted TLAST.
- Output registers:
  - One register stage per port; latency is 1 cycle from accept to mX_tvalid.
  - mX_tvalid clears on mX_tready unless a new beat loads in the same cycle. Back-to-back beats give full throughput.
  - Outputs hold stable while tvalid=1 and tready=0.
- Simultaneous events:
  - A port drain and a new load in the same cycle → the register takes the new beat, tvalid stays 1.
  - Counter increments are single-cycle; at most one counter changes per cycle.
- Metadata costs one input cycle and produces no output beat. The output packet therefore carries exactly the payload beats.

Decomposition:
- Shared package pkt_meta_pkg:
  - ETYPE_LSB=96, ETYPE_W=16, ETYPE_IPV4=16'h0800, ETYPE_IPV6=16'h86DD.
  - state_t enum {META, FWD, DROP}.
  - Destination enum {DST_P0, DST_P1, DST_DROP}.
  - Reused by the ingress stage and later stages.
- One natural sub-module: axis_out_reg, the single-entry valid/ready output register. It is instantiated twice, with a load-enable input and tdata/tlast/terr.

Test Plan:
- IPv4, 3 payload beats (metadata etype 0x0800) with both readys=1 → m0 shows 3 beats one cycle after each accept, tlast on beat 3; fwd0_cnt=1; m1_tvalid never 1.
- IPv6, 2 beats with m1_tready held 0 for 4 cycles → s_tready=0 once m1 holds beat 1, beat 1 held stable, then both delivered in order; fwd1_cnt=1.
- EtherType 0x0806, 4 beats → no output valid; s_tready=1 throughout; drop_cnt=1; next IPv4 packet forwards normally.
- Errors:
  - Metadata with TLAST=1 → err_cnt=1, stay META.
  - Payload beat as first beat (TUSER=0, TLAST=0) followed by a TLAST beat → err_cnt=2 cumulative, both discarded.
- Premature metadata at beat 2 of an IPv4 packet (TLAST=0), then a TLAST beat → m0 emits beat 2 with tlast=1, terr=1; err_cnt+1; the trailing beat is dropped.
- Reset asserted mid-FWD with m0_tvalid=1 → m0_tvalid=0 immediately (asynchronous); counters=0; after release a 1-beat IPv6 packet forwards correctly.
